// File: rtl/encoder_trig_gen.sv
// Quadrature (x4) encoder to camera line-trigger generator with divider, pulse FSM and status counters.
// Define ENC_TRIG_BACKTRACK_EN to compile in reverse-step debt (backtrack) compensation.
module encoder_trig_gen #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             reg_trig_en,
   input  logic [15:0]      reg_trig_div,
   input  logic [15:0]      reg_trig_width,
   input  logic             reg_backtrack_en,
   input  logic             reg_trig_clr,
   input  logic             phase_encoder_a_in,
   input  logic             phase_encoder_b_in,
   output logic             trig_out,
   output logic [CNT_W-1:0] reg_trig_cnt,
   output logic [CNT_W-1:0] reg_trig_miss_cnt,
   output logic [CNT_W-1:0] reg_enc_err_cnt,
   output logic [15:0]      reg_backtrack_depth
);

   typedef enum logic [1:0] {IDLE, HIGH, GUARD} state_t;

   state_t      state, state_nxt;
   logic        a_s0, a_s1, a_s2, b_s0, b_s1, b_s2;
   logic        a_chg, b_chg, enc_err, fwd_step;
   logic [15:0] div_cnt, div_nxt, width_cnt, width_nxt;
   logic [15:0] div_lim, width_eff;
   logic        eff_step, fire, trig_inc, miss_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {a_s0, a_s1, a_s2} <= 3'b000;
         {b_s0, b_s1, b_s2} <= 3'b000;
      end else begin
         {a_s0, a_s1, a_s2} <= {phase_encoder_a_in, a_s0, a_s1};
         {b_s0, b_s1, b_s2} <= {phase_encoder_b_in, b_s0, b_s1};
      end
   end

   // With a single changing input, forward steps leave A^B == 1 after an A edge and A==B after a B edge.
   assign a_chg    = a_s1 ^ a_s2;
   assign b_chg    = b_s1 ^ b_s2;
   assign enc_err  = a_chg & b_chg;
   assign fwd_step = (a_chg & ~b_chg & (a_s1 ^ b_s1)) | (b_chg & ~a_chg & ~(a_s1 ^ b_s1));

   assign div_lim   = (reg_trig_div == 16'd0) ? 16'd0 : reg_trig_div - 16'd1;
   assign width_eff = (reg_trig_width == 16'd0) ? 16'd1 : reg_trig_width;

`ifdef ENC_TRIG_BACKTRACK_EN
   logic        rev_step;
   logic [15:0] debt, debt_nxt;
   assign rev_step            = (a_chg & ~b_chg & ~(a_s1 ^ b_s1)) | (b_chg & ~a_chg & (a_s1 ^ b_s1));
   assign reg_backtrack_depth = debt;
`else
   // Backtrack compiled out: the enable is ignored and the depth reads as zero.
   assign reg_backtrack_depth = {16{reg_backtrack_en & 1'b0}};
`endif

   always_comb begin
      eff_step = 1'b0;
      fire     = 1'b0;
      div_nxt  = div_cnt;
`ifdef ENC_TRIG_BACKTRACK_EN
      debt_nxt = debt;
`endif
      if (!reg_trig_en) begin
         div_nxt = 16'd0;
`ifdef ENC_TRIG_BACKTRACK_EN
         debt_nxt = 16'd0;
`endif
      end else begin
`ifdef ENC_TRIG_BACKTRACK_EN
         if (reg_backtrack_en) begin
            if (rev_step) begin
               if (debt != 16'hFFFF) debt_nxt = debt + 16'd1;
            end else if (fwd_step) begin
               if (debt != 16'd0) debt_nxt = debt - 16'd1;
               else eff_step = 1'b1;
            end
         end else begin
            debt_nxt = 16'd0;
            eff_step = fwd_step;
         end
`else
         eff_step = fwd_step;
`endif
         // >= so that lowering the divider mid-count fires on the next step
         if (eff_step) begin
            if (div_cnt >= div_lim) begin
               div_nxt = 16'd0;
               fire    = 1'b1;
            end else begin
               div_nxt = div_cnt + 16'd1;
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      width_nxt = width_cnt;
      trig_inc  = 1'b0;
      miss_inc  = 1'b0;
      case (state)
         IDLE: begin
            if (fire) begin
               state_nxt = HIGH;
               width_nxt = 16'd1;
               trig_inc  = 1'b1;
            end
         end
         HIGH: begin
            miss_inc = fire;
            if (width_cnt == width_eff) state_nxt = GUARD;
            else width_nxt = width_cnt + 16'd1;
         end
         GUARD: begin
            miss_inc  = fire;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         width_cnt         <= 16'd0;
         div_cnt           <= 16'd0;
         reg_trig_cnt      <= '0;
         reg_trig_miss_cnt <= '0;
         reg_enc_err_cnt   <= '0;
`ifdef ENC_TRIG_BACKTRACK_EN
         debt              <= 16'd0;
`endif
      end else if (reg_trig_clr) begin
         state             <= IDLE;
         width_cnt         <= 16'd0;
         div_cnt           <= 16'd0;
         reg_trig_cnt      <= '0;
         reg_trig_miss_cnt <= '0;
         reg_enc_err_cnt   <= '0;
`ifdef ENC_TRIG_BACKTRACK_EN
         debt              <= 16'd0;
`endif
      end else begin
         state     <= state_nxt;
         width_cnt <= width_nxt;
         div_cnt   <= div_nxt;
`ifdef ENC_TRIG_BACKTRACK_EN
         debt      <= debt_nxt;
`endif
         if (trig_inc) reg_trig_cnt <= reg_trig_cnt + 1'b1;
         if (miss_inc) reg_trig_miss_cnt <= reg_trig_miss_cnt + 1'b1;
         if (enc_err) reg_enc_err_cnt <= reg_enc_err_cnt + 1'b1;
      end
   end

   assign trig_out = (state == HIGH);

endmodule

// File: tb/tb_encoder_trig_gen.sv
// Directed testbench for encoder_trig_gen: sweep, latency, backtrack/config, miss, error, clear and reset.
module tb_encoder_trig_gen;
   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             reg_trig_en;
   logic [15:0]      reg_trig_div;
   logic [15:0]      reg_trig_width;
   logic             reg_backtrack_en;
   logic             reg_trig_clr;
   logic             enc_a, enc_b;
   logic             trig_out;
   logic [CNT_W-1:0] reg_trig_cnt, reg_trig_miss_cnt, reg_enc_err_cnt;
   logic [15:0]      reg_backtrack_depth;

   int checks = 0;
   int failures = 0;
   int phase = 0;

   // pulse monitor: records the high time of each completed pulse
   int   pulse_cnt = 0;
   int   run_len = 0;
   int   widths[0:63];
   logic prev_trig = 1'b0;

   encoder_trig_gen #(.CNT_W(CNT_W)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .reg_trig_en         (reg_trig_en),
      .reg_trig_div        (reg_trig_div),
      .reg_trig_width      (reg_trig_width),
      .reg_backtrack_en    (reg_backtrack_en),
      .reg_trig_clr        (reg_trig_clr),
      .phase_encoder_a_in  (enc_a),
      .phase_encoder_b_in  (enc_b),
      .trig_out            (trig_out),
      .reg_trig_cnt        (reg_trig_cnt),
      .reg_trig_miss_cnt   (reg_trig_miss_cnt),
      .reg_enc_err_cnt     (reg_enc_err_cnt),
      .reg_backtrack_depth (reg_backtrack_depth)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (trig_out) begin
         run_len = run_len + 1;
      end else if (prev_trig) begin
         if (pulse_cnt < 64) widths[pulse_cnt] = run_len;
         pulse_cnt = pulse_cnt + 1;
         run_len = 0;
      end
      prev_trig = trig_out;
   end

   // forward order of (A,B): 00 -> 10 -> 11 -> 01 -> 00
   task automatic step(input bit fwd, input int gap);
      phase = fwd ? (phase + 1) % 4 : (phase + 3) % 4;
      case (phase)
         0: begin enc_a = 1'b0; enc_b = 1'b0; end
         1: begin enc_a = 1'b1; enc_b = 1'b0; end
         2: begin enc_a = 1'b1; enc_b = 1'b1; end
         default: begin enc_a = 1'b0; enc_b = 1'b1; end
      endcase
      repeat (gap) @(negedge clk);
   endtask

   task automatic do_clear();
      reg_trig_clr = 1'b1;
      @(negedge clk);
      reg_trig_clr = 1'b0;
      @(negedge clk);
   endtask

   task automatic toggle_both(input int gap);
      enc_a = ~enc_a;
      enc_b = ~enc_b;
      repeat (gap) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      reg_trig_en = 1'b1; reg_trig_div = 16'd1; reg_trig_width = 16'd3;
      reg_backtrack_en = 1'b0; reg_trig_clr = 1'b0;
      enc_a = 1'b0; enc_b = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (trig_out !== 1'b0) begin failures++; $display("FAIL reset_trig_out actual=%0b required=0", trig_out); end
      checks++; if (reg_trig_cnt !== 32'd0) begin failures++; $display("FAIL reset_trig_cnt actual=%0d required=0", reg_trig_cnt); end
      checks++; if (reg_trig_miss_cnt !== 32'd0) begin failures++; $display("FAIL reset_miss_cnt actual=%0d required=0", reg_trig_miss_cnt); end
      checks++; if (reg_enc_err_cnt !== 32'd0) begin failures++; $display("FAIL reset_err_cnt actual=%0d required=0", reg_enc_err_cnt); end
      checks++; if (reg_backtrack_depth !== 16'd0) begin failures++; $display("FAIL reset_depth actual=%0d required=0", reg_backtrack_depth); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (trig_out !== 1'b0) begin failures++; $display("FAIL reset_release_trig actual=%0b required=0", trig_out); end
   endtask

   task automatic test_forward_sweep();
      int base;
      reg_trig_div = 16'd4; reg_trig_width = 16'd3; reg_backtrack_en = 1'b0;
      do_clear();
      base = pulse_cnt;
      for (int i = 0; i < 3; i++) step(1'b1, 10);
      step(1'b1, 0);
      @(negedge clk);
      checks++; if (trig_out !== 1'b0) begin failures++; $display("FAIL latency_e0 actual=%0b required=0", trig_out); end
      @(negedge clk);
      checks++; if (trig_out !== 1'b0) begin failures++; $display("FAIL latency_e1 actual=%0b required=0", trig_out); end
      @(negedge clk);
      checks++; if (trig_out !== 1'b1) begin failures++; $display("FAIL latency_e2 actual=%0b required=1", trig_out); end
      repeat (7) @(negedge clk);
      for (int i = 4; i < 16; i++) step(1'b1, 10);
      repeat (10) @(negedge clk);
      checks++; if (pulse_cnt - base !== 4) begin failures++; $display("FAIL sweep_pulses actual=%0d required=4", pulse_cnt - base); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (widths[base+k] !== 3) begin failures++; $display("FAIL sweep_width%0d actual=%0d required=3", k, widths[base+k]); end
      end
      checks++; if (reg_trig_cnt !== 32'd4) begin failures++; $display("FAIL sweep_trig_cnt actual=%0d required=4", reg_trig_cnt); end
      checks++; if (reg_trig_miss_cnt !== 32'd0) begin failures++; $display("FAIL sweep_miss_cnt actual=%0d required=0", reg_trig_miss_cnt); end
   endtask

   task automatic test_miss();
      int base;
      reg_trig_div = 16'd1; reg_trig_width = 16'd20;
      do_clear();
      base = pulse_cnt;
      for (int i = 0; i < 4; i++) step(1'b1, 5);
      repeat (30) @(negedge clk);
      checks++; if (reg_trig_cnt !== 32'd1) begin failures++; $display("FAIL miss_trig_cnt actual=%0d required=1", reg_trig_cnt); end
      checks++; if (reg_trig_miss_cnt !== 32'd3) begin failures++; $display("FAIL miss_miss_cnt actual=%0d required=3", reg_trig_miss_cnt); end
      checks++; if (pulse_cnt - base !== 1) begin failures++; $display("FAIL miss_pulses actual=%0d required=1", pulse_cnt - base); end
      checks++; if (widths[base] !== 20) begin failures++; $display("FAIL miss_width actual=%0d required=20", widths[base]); end
   endtask

   task automatic test_error();
      int base;
      reg_trig_div = 16'd1; reg_trig_width = 16'd3;
      do_clear();
      base = pulse_cnt;
      toggle_both(6);
      toggle_both(6);
      checks++; if (reg_enc_err_cnt !== 32'd2) begin failures++; $display("FAIL err_cnt actual=%0d required=2", reg_enc_err_cnt); end
      checks++; if (reg_trig_cnt !== 32'd0) begin failures++; $display("FAIL err_trig_cnt actual=%0d required=0", reg_trig_cnt); end
      checks++; if (pulse_cnt - base !== 0) begin failures++; $display("FAIL err_pulses actual=%0d required=0", pulse_cnt - base); end
   endtask

`ifdef ENC_TRIG_BACKTRACK_EN
   task automatic test_backtrack();
      reg_trig_div = 16'd1; reg_trig_width = 16'd3; reg_backtrack_en = 1'b1;
      do_clear();
      for (int i = 0; i < 5; i++) step(1'b1, 10);
      checks++; if (reg_trig_cnt !== 32'd5) begin failures++; $display("FAIL bt_fwd1_cnt actual=%0d required=5", reg_trig_cnt); end
      for (int i = 0; i < 3; i++) step(1'b0, 10);
      checks++; if (reg_backtrack_depth !== 16'd3) begin failures++; $display("FAIL bt_depth_peak actual=%0d required=3", reg_backtrack_depth); end
      checks++; if (reg_trig_cnt !== 32'd5) begin failures++; $display("FAIL bt_rev_cnt actual=%0d required=5", reg_trig_cnt); end
      for (int i = 0; i < 5; i++) step(1'b1, 10);
      checks++; if (reg_trig_cnt !== 32'd7) begin failures++; $display("FAIL bt_total_cnt actual=%0d required=7", reg_trig_cnt); end
      checks++; if (reg_backtrack_depth !== 16'd0) begin failures++; $display("FAIL bt_depth_end actual=%0d required=0", reg_backtrack_depth); end
      reg_backtrack_en = 1'b0;
   endtask
`else
   task automatic test_config_no_backtrack();
      reg_trig_div = 16'd1; reg_trig_width = 16'd3; reg_backtrack_en = 1'b1;
      do_clear();
      for (int i = 0; i < 3; i++) step(1'b0, 10);
      checks++; if (reg_backtrack_depth !== 16'd0) begin failures++; $display("FAIL cfg_depth_rev actual=%0d required=0", reg_backtrack_depth); end
      checks++; if (reg_trig_cnt !== 32'd0) begin failures++; $display("FAIL cfg_rev_cnt actual=%0d required=0", reg_trig_cnt); end
      for (int i = 0; i < 3; i++) step(1'b1, 10);
      checks++; if (reg_trig_cnt !== 32'd3) begin failures++; $display("FAIL cfg_trig_cnt actual=%0d required=3", reg_trig_cnt); end
      checks++; if (reg_backtrack_depth !== 16'd0) begin failures++; $display("FAIL cfg_depth_end actual=%0d required=0", reg_backtrack_depth); end
      reg_backtrack_en = 1'b0;
   endtask
`endif

   task automatic test_clear_and_reset();
      int n;
      reg_trig_div = 16'd1; reg_trig_width = 16'd5;
      do_clear();
      toggle_both(4);
      toggle_both(4);
      step(1'b1, 0);
      n = 0;
      while (!trig_out && n < 10) begin @(negedge clk); n++; end
      checks++; if (trig_out !== 1'b1) begin failures++; $display("FAIL clr_pulse_start actual=%0b required=1", trig_out); end
      @(negedge clk);
      reg_trig_clr = 1'b1;
      @(negedge clk);
      reg_trig_clr = 1'b0;
      checks++; if (trig_out !== 1'b0) begin failures++; $display("FAIL clr_trig_out actual=%0b required=0", trig_out); end
      checks++; if (reg_trig_cnt !== 32'd0) begin failures++; $display("FAIL clr_trig_cnt actual=%0d required=0", reg_trig_cnt); end
      checks++; if (reg_enc_err_cnt !== 32'd0) begin failures++; $display("FAIL clr_err_cnt actual=%0d required=0", reg_enc_err_cnt); end
      checks++; if (reg_trig_miss_cnt !== 32'd0) begin failures++; $display("FAIL clr_miss_cnt actual=%0d required=0", reg_trig_miss_cnt); end
      repeat (10) @(negedge clk);
      toggle_both(4);
      toggle_both(4);
      step(1'b1, 0);
      n = 0;
      while (!trig_out && n < 10) begin @(negedge clk); n++; end
      checks++; if (trig_out !== 1'b1) begin failures++; $display("FAIL rst_pulse_start actual=%0b required=1", trig_out); end
      checks++; if (reg_enc_err_cnt !== 32'd2) begin failures++; $display("FAIL rst_pre_err_cnt actual=%0d required=2", reg_enc_err_cnt); end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (trig_out !== 1'b0) begin failures++; $display("FAIL rst_async_trig actual=%0b required=0", trig_out); end
      checks++; if (reg_trig_cnt !== 32'd0) begin failures++; $display("FAIL rst_trig_cnt actual=%0d required=0", reg_trig_cnt); end
      checks++; if (reg_enc_err_cnt !== 32'd0) begin failures++; $display("FAIL rst_err_cnt actual=%0d required=0", reg_enc_err_cnt); end
      checks++; if (reg_trig_miss_cnt !== 32'd0) begin failures++; $display("FAIL rst_miss_cnt actual=%0d required=0", reg_trig_miss_cnt); end
      checks++; if (reg_backtrack_depth !== 16'd0) begin failures++; $display("FAIL rst_depth actual=%0d required=0", reg_backtrack_depth); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_forward_sweep();
      test_miss();
      test_error();
`ifdef ENC_TRIG_BACKTRACK_EN
      test_backtrack();
`else
      test_config_no_backtrack();
`endif
      test_clear_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
